// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Decoder-facing constants live here so the main decoder can reuse them.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } md_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  function automatic logic is_div_op(md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage bundle between the pipeline and the muldiv unit.
// master = pipeline side, slave = muldiv_unit side.
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start_i;
  logic [2:0]       funct3_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, funct3_i, op_a_i, op_b_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_operand_prep.sv
// Operand magnitudes, result sign and special-case detection.
// Specials (div by zero, signed overflow) get their final value here.
import muldiv_pkg::*;

module muldiv_operand_prep #(
  parameter int WIDTH = 32
) (
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             neg,
  output logic             special,
  output logic [WIDTH-1:0] spec_res
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic sa;
  logic sb;
  logic is_div;
  logic is_rem;
  logic div_zero;
  logic ovf;

  // sign extraction, magnitudes and special-result selection
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        sa = a[WIDTH-1];
        sb = b[WIDTH-1];
      end
      OP_MULHSU: sa = a[WIDTH-1];
      default: ;
    endcase
    mag_a    = sa ? (~a + 1'b1) : a;
    mag_b    = sb ? (~b + 1'b1) : b;
    is_div   = is_div_op(op);
    is_rem   = is_div & op[1];
    neg      = is_rem ? sa : (sa ^ sb);
    div_zero = is_div && (b == '0);
    ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
               (a == MOST_NEG) && (b == '1);
    special  = div_zero | ovf;
    spec_res = '0;
    unique case (1'b1)
      div_zero: spec_res = is_rem ? a : '1;
      ovf:      spec_res = is_rem ? '0 : a;
      default:  spec_res = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
// Define MULDIV_EARLY_OUT_EN to finish multiplies once the multiplier runs out.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int W2 = 2 * WIDTH;

  md_state_e        state;
  md_state_e        state_nx;
  md_op_e           op;
  md_op_e           op_in;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic             special;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             last;
  logic             early;

  logic [WIDTH-1:0] p_mag_a;
  logic [WIDTH-1:0] p_mag_b;
  logic             p_neg;
  logic             p_special;
  logic [WIDTH-1:0] p_spec;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    div_nx;
  logic [W2-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] final_res;

  assign op_in = md_op_e'(bus.funct3_i);

  muldiv_operand_prep #(.WIDTH(WIDTH)) u_prep (
    .op       (op_in),
    .a        (bus.op_a_i),
    .b        (bus.op_b_i),
    .mag_a    (p_mag_a),
    .mag_b    (p_mag_b),
    .neg      (p_neg),
    .special  (p_special),
    .spec_res (p_spec)
  );

  assign last = (cnt == CNT_W'(1));

`ifdef MULDIV_EARLY_OUT_EN
  assign early = !is_div_op(op) && (mplier[WIDTH-1:1] == '0);
`else
  assign early = 1'b0;
`endif

  assign bus.busy_o   = (state != IDLE);
  assign bus.done_o   = done;
  assign bus.result_o = result;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state: flush wins, specials bypass CALC
  always_comb begin
    state_nx = state;
    if (bus.flush_i) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start_i) state_nx = p_special ? FINISH : CALC;
        CALC:    if (last || early) state_nx = FINISH;
        FINISH:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // restoring divide step and sign-corrected output selection
  always_comb begin
    rem_sh = acc[W2-1:WIDTH-1];
    diff   = rem_sh - {1'b0, mplier};
    if (!diff[WIDTH])
      div_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_nx = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    prod_s = neg ? (~acc + 1'b1) : acc;
    quo_s  = neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_s  = neg ? (~acc[W2-1:WIDTH] + 1'b1) : acc[W2-1:WIDTH];
    final_res = acc[WIDTH-1:0];
    if (!special) begin
      unique case (op)
        OP_MUL:                       final_res = prod_s[WIDTH-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[W2-1:WIDTH];
        OP_DIV, OP_DIVU:              final_res = quo_s;
        OP_REM, OP_REMU:              final_res = rem_s;
        default:                      final_res = acc[WIDTH-1:0];
      endcase
    end
  end

  // datapath: capture, iterate, write back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op      <= OP_MUL;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      special <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (bus.flush_i) begin
        cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start_i) begin
              op      <= op_in;
              neg     <= p_neg;
              special <= p_special;
              cnt     <= CNT_W'(WIDTH);
              mplier  <= p_mag_b;
              mcand   <= {{WIDTH{1'b0}}, p_mag_a};
              if (p_special)
                acc <= {{WIDTH{1'b0}}, p_spec};
              else if (is_div_op(op_in))
                acc <= {{WIDTH{1'b0}}, p_mag_a};
              else
                acc <= '0;
            end
          end
          CALC: begin
            cnt <= cnt - 1'b1;
            if (is_div_op(op)) begin
              acc <= div_nx;
            end else begin
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
          end
          FINISH: begin
            done   <= 1'b1;
            result <= final_res;
            cnt    <= '0;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule
